xy_route_arbiter: RTL and testbench
===================================

Name: xy_route_arbiter

Overview:
- Routing and arbitration stage for the simple mesh XY switch, directly upstream of the switch control unit.
- Inspects the head-of-queue packet header of every valid input port and computes its output port with dimension-ordered XY routing.
- Picks one input round-robin, skipping inputs whose target output is full.
- Drives the registered mux_in_sel/mux_out_sel pair that the control unit and crossbar consume, and holds it until the transfer completes.

Parameters:
- PORT_N, 5: number of ports. Fixed at 5 for XY semantics: 0=LOCAL, 1=NORTH, 2=EAST, 3=SOUTH, 4=WEST.
- DATA_W, 8: packet width. Must be >= X_W+Y_W.
- X_W, 2: destination X coordinate width.
- Y_W, 2: destination Y coordinate width.
- X_CORD, 0: this router's X coordinate.
- Y_CORD, 0: this router's Y coordinate.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous, active-high reset
- vld_input_i  input  PORT_N  head packet of port i is valid (from control unit vld_input_o)
- data_i  input  PORT_N*DATA_W  head packets; port i at bits [i*DATA_W +: DATA_W]
- full_i  input  PORT_N  output port full flags
- wr_en_i  input  PORT_N  output write strobes (from control unit wr_en_o); marks transfer completion
- mux_in_sel_o  output  $clog2(PORT_N)  granted input port
- mux_out_sel_o  output  $clog2(PORT_N)  routed output port of granted input
- grant_vld_o  output  1  selects are valid; integration gates the downstream write enable with it
- route_err_o  output  1  sticky U-turn error flag

Behaviour:
- Reset (rst_ni=1, asynchronous): state=IDLE, rr_ptr=0, mux_in_sel_o=0, mux_out_sel_o=0, grant_vld_o=0, route_err_o=0.
- Header fields: dest_y = data[Y_W-1:0]; dest_x = data[X_W+Y_W-1:Y_W].
- Route function is combinational, one instance per port, evaluated in this order:
  - dest_x > X_CORD -> EAST(2)
  - dest_x < X_CORD -> WEST(4)
  - else dest_y > Y_CORD -> NORTH(1)
  - else dest_y < Y_CORD -> SOUTH(3)
  - else LOCAL(0)
- Comparisons are unsigned.
- Eligibility: port i is eligible when vld_input_i[i] & ~full_i[route(i)].
- FSM has two states, IDLE and GRANT.
- IDLE:
  - Search eligible ports starting at rr_ptr and wrapping modulo PORT_N; take the first hit.
  - If a hit is found, at the next edge: mux_in_sel_o<=hit, mux_out_sel_o<=route(hit), grant_vld_o<=1, state<=GRANT.
  - If no hit, stay in IDLE and hold the selects at their previous values.
- GRANT:
  - Selects are frozen. full_i changes are ignored while granted; the downstream stage stalls.
  - Completion: when wr_en_i[mux_out_sel_o]=1, at the edge state<=IDLE, grant_vld_o<=0, rr_ptr<=(mux_in_sel_o+1) mod PORT_N.
  - Abort: if vld_input_i[mux_in_sel_o]=0 and there is no completion, return to IDLE with rr_ptr unchanged.
  - wr_en_i bits other than mux_out_sel_o are ignored.
- Latency:
  - Eligible in cycle N -> grant_vld_o=1 in cycle N+1.
  - Completion in cycle M -> grant_vld_o=0 in M+1.
  - One mandatory IDLE bubble per packet, so peak rate is 1 packet per 2 cycles.
- U-turn error: granting input p≠0 whose route equals p sets route_err_o=1. It stays set until reset. The packet is still routed.
- Loopback: LOCAL->LOCAL is legal and does not set the error.
- Fairness: the last granted port has lowest priority in the next search. No port waits more than PORT_N-1 grants while continuously eligible.
- Reset asserted mid-GRANT: outputs return to reset values immediately. The next grant after release starts from port 0.

Test Plan:
- Reset mid-grant: grant active on port 3, assert rst_ni -> grant_vld_o, selects, and rr_ptr go to 0 without waiting for a clock edge. After release, only port 4 valid -> grant in_sel=4.
- XY east route (X_CORD=1, Y_CORD=1): port 0 valid, data=8'b0000_1001 (x=2, y=1) -> next cycle in_sel=0, out_sel=2, grant_vld_o=1. Pulse wr_en_i=5'b00100 -> grant_vld_o=0 the following cycle.
- X-before-Y: port 1 header x=0, y=2 -> out_sel=4 (WEST), not NORTH.
- Round-robin: ports 1 and 3 continuously valid with dest (1,1), each grant completed one cycle later -> grants alternate 1,3,1,3 with out_sel=0.
- Full skip: port 0 routed EAST with full_i[2]=1, port 4 routed LOCAL -> port 4 granted first. Clear full_i[2] -> port 0 granted next.
- U-turn and abort: port 2 (EAST) header x=3 -> out_sel=2 and route_err_o=1, sticky. New grant on port 1, drop vld_input_i[1] -> IDLE next cycle with rr_ptr unchanged.

Source files
------------

// File: rtl/xy_route_arbiter.sv
// Routing and arbitration stage for the mesh XY switch.
// Computes a dimension-ordered (X first, then Y) output port for the head
// packet of every input, picks one eligible input round-robin, and holds the
// registered crossbar selects until the granted transfer is written out.
module xy_route_arbiter #(
  parameter int PORT_N = 5,
  parameter int DATA_W = 8,
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  parameter int X_CORD = 0,
  parameter int Y_CORD = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [PORT_N-1:0]          vld_input_i,
  input  logic [PORT_N*DATA_W-1:0]   data_i,
  input  logic [PORT_N-1:0]          full_i,
  input  logic [PORT_N-1:0]          wr_en_i,
  output logic [$clog2(PORT_N)-1:0]  mux_in_sel_o,
  output logic [$clog2(PORT_N)-1:0]  mux_out_sel_o,
  output logic                       grant_vld_o,
  output logic                       route_err_o
);

  localparam int SEL_W = $clog2(PORT_N);
  localparam int HDR_W = X_W + Y_W;

  localparam logic [SEL_W-1:0] P_LOCAL = SEL_W'(0);
  localparam logic [SEL_W-1:0] P_NORTH = SEL_W'(1);
  localparam logic [SEL_W-1:0] P_EAST  = SEL_W'(2);
  localparam logic [SEL_W-1:0] P_SOUTH = SEL_W'(3);
  localparam logic [SEL_W-1:0] P_WEST  = SEL_W'(4);
  localparam logic [SEL_W-1:0] P_LAST  = SEL_W'(PORT_N - 1);

  localparam logic [X_W-1:0] MY_X = X_W'(X_CORD);
  localparam logic [Y_W-1:0] MY_Y = Y_W'(Y_CORD);

  typedef enum logic {IDLE, GRANT} state_t;

  // X is resolved fully before Y, so a packet never turns from Y back into X.
  function automatic logic [SEL_W-1:0] xy_route(input logic [HDR_W-1:0] hdr);
    logic [X_W-1:0] dest_x;
    logic [Y_W-1:0] dest_y;
    dest_y = hdr[Y_W-1:0];
    dest_x = hdr[HDR_W-1:Y_W];
    if (dest_x > MY_X)      return P_EAST;
    else if (dest_x < MY_X) return P_WEST;
    else if (dest_y > MY_Y) return P_NORTH;
    else if (dest_y < MY_Y) return P_SOUTH;
    else                    return P_LOCAL;
  endfunction

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]  in_sel_d, out_sel_d;
  logic              grant_vld_d, route_err_d;

  logic [SEL_W-1:0]  route [PORT_N];
  logic [PORT_N-1:0] eligible;
  logic              hit_found;
  logic [SEL_W-1:0]  hit_idx;
  logic              xfer_done;
  logic              xfer_abort;
  logic              uturn;

  // Payload bits above the header are carried through the crossbar, not inspected here.
  logic unused_payload;
  assign unused_payload = ^data_i;

  // Per-port route and eligibility (valid head packet whose target output has room).
  always_comb begin
    for (int i = 0; i < PORT_N; i++) begin
      route[i]    = xy_route(data_i[i*DATA_W +: HDR_W]);
      eligible[i] = vld_input_i[i] & ~full_i[route[i]];
    end
  end

  // Round-robin search from rr_ptr; scanning backwards lets the nearest hit win.
  always_comb begin
    int idx;
    hit_found = 1'b0;
    hit_idx   = '0;
    idx       = 0;
    for (int k = PORT_N - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= PORT_N) idx = idx - PORT_N;
      if (eligible[idx]) begin
        hit_found = 1'b1;
        hit_idx   = SEL_W'(idx);
      end
    end
  end

  assign xfer_done  = wr_en_i[mux_out_sel_o];
  assign xfer_abort = ~vld_input_i[mux_in_sel_o] & ~xfer_done;
  assign uturn      = (hit_idx != P_LOCAL) && (route[hit_idx] == hit_idx);

  // State and registered selects; reset drops everything immediately.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      mux_in_sel_o  <= '0;
      mux_out_sel_o <= '0;
      grant_vld_o   <= 1'b0;
      route_err_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      mux_in_sel_o  <= in_sel_d;
      mux_out_sel_o <= out_sel_d;
      grant_vld_o   <= grant_vld_d;
      route_err_o   <= route_err_d;
    end
  end

  // Next state: grant on any hit, leave GRANT on completion or when the input drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit_found) state_d = GRANT;
      GRANT:   if (xfer_done || xfer_abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the selects, grant flag, pointer and sticky error.
  always_comb begin
    in_sel_d    = mux_in_sel_o;
    out_sel_d   = mux_out_sel_o;
    grant_vld_d = grant_vld_o;
    rr_ptr_d    = rr_ptr_q;
    route_err_d = route_err_o;
    case (state_q)
      IDLE: begin
        if (hit_found) begin
          in_sel_d    = hit_idx;
          out_sel_d   = route[hit_idx];
          grant_vld_d = 1'b1;
          route_err_d = route_err_o | uturn;
        end
      end
      GRANT: begin
        if (xfer_done) begin
          grant_vld_d = 1'b0;
          rr_ptr_d    = (mux_in_sel_o == P_LAST) ? '0 : mux_in_sel_o + SEL_W'(1);
        end else if (xfer_abort) begin
          grant_vld_d = 1'b0;
        end
      end
      default: grant_vld_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_xy_route_arbiter.sv
// Directed testbench for xy_route_arbiter, router placed at (1,1).
module tb_xy_route_arbiter;

  logic        clk;
  logic        rst;
  logic [4:0]  vld;
  logic [39:0] data;
  logic [4:0]  full;
  logic [4:0]  wr_en;
  logic [2:0]  in_sel;
  logic [2:0]  out_sel;
  logic        grant;
  logic        err;

  int errors = 0;
  int checks = 0;

  xy_route_arbiter #(
    .PORT_N(5), .DATA_W(8), .X_W(2), .Y_W(2), .X_CORD(1), .Y_CORD(1)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst),
    .vld_input_i  (vld),
    .data_i       (data),
    .full_i       (full),
    .wr_en_i      (wr_en),
    .mux_in_sel_o (in_sel),
    .mux_out_sel_o(out_sel),
    .grant_vld_o  (grant),
    .route_err_o  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] hdr(input logic [1:0] x, input logic [1:0] y);
    return {4'b0000, x, y};
  endfunction

  task automatic set_data(input int p, input logic [7:0] v);
    data[p*8 +: 8] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    vld   = '0;
    full  = '0;
    wr_en = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; data = '0; clear_inputs();
    #1 rst = 1'b1;
    #1;
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant: got %b want 0", grant); end
    checks++; if (in_sel !== 3'd0) begin errors++; $display("[TB] FAIL reset_in_sel: got %0d want 0", in_sel); end
    checks++; if (out_sel !== 3'd0) begin errors++; $display("[TB] FAIL reset_out_sel: got %0d want 0", out_sel); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    step();
    rst = 1'b0;
    step();
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_valid: got %b want 0", grant); end
  endtask

  task automatic test_full_skip();
    set_data(0, hdr(2'd2, 2'd1));
    set_data(4, hdr(2'd1, 2'd1));
    full = 5'b00100; vld = 5'b00001;
    step();
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL full_block: got %b want 0", grant); end
    vld = 5'b10001;
    step();
    checks++; if (grant !== 1'b1 || in_sel !== 3'd4 || out_sel !== 3'd0) begin errors++;
      $display("[TB] FAIL full_skip_grant: got g=%b in=%0d out=%0d want g=1 in=4 out=0", grant, in_sel, out_sel); end
    wr_en = 5'b00001;
    step();
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL full_skip_done: got %b want 0", grant); end
    wr_en = '0; vld = 5'b00001; full = '0;
    step();
    checks++; if (grant !== 1'b1 || in_sel !== 3'd0 || out_sel !== 3'd2) begin errors++;
      $display("[TB] FAIL full_clear_grant: got g=%b in=%0d out=%0d want g=1 in=0 out=2", grant, in_sel, out_sel); end
    full = 5'b00100;
    step();
    checks++; if (grant !== 1'b1 || in_sel !== 3'd0) begin errors++;
      $display("[TB] FAIL full_ignored_in_grant: got g=%b in=%0d want g=1 in=0", grant, in_sel); end
    wr_en = 5'b00100;
    step();
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL full_done2: got %b want 0", grant); end
    clear_inputs();
  endtask

  task automatic test_east_route();
    set_data(0, 8'b0000_1001);
    vld = 5'b00001;
    step();
    checks++; if (grant !== 1'b1 || in_sel !== 3'd0 || out_sel !== 3'd2 || err !== 1'b0) begin errors++;
      $display("[TB] FAIL east_grant: got g=%b in=%0d out=%0d e=%b want g=1 in=0 out=2 e=0", grant, in_sel, out_sel, err); end
    wr_en = 5'b00100;
    step();
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL east_done: got %b want 0", grant); end
    checks++; if (in_sel !== 3'd0 || out_sel !== 3'd2) begin errors++;
      $display("[TB] FAIL east_hold_sel: got in=%0d out=%0d want in=0 out=2", in_sel, out_sel); end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int exp_seq [4] = '{1, 3, 1, 3};
    set_data(1, hdr(2'd1, 2'd1));
    set_data(3, hdr(2'd1, 2'd1));
    vld = 5'b01010;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (grant !== 1'b1 || in_sel !== 3'(exp_seq[i]) || out_sel !== 3'd0) begin errors++;
        $display("[TB] FAIL rr_grant%0d: got g=%b in=%0d out=%0d want g=1 in=%0d out=0", i, grant, in_sel, out_sel, exp_seq[i]); end
      wr_en = 5'b00001;
      step();
      checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL rr_done%0d: got %b want 0", i, grant); end
      wr_en = '0;
    end
    clear_inputs();
  endtask

  task automatic test_x_before_y();
    set_data(1, hdr(2'd0, 2'd2));
    vld = 5'b00010;
    step();
    checks++; if (grant !== 1'b1 || in_sel !== 3'd1 || out_sel !== 3'd4) begin errors++;
      $display("[TB] FAIL xfirst_grant: got g=%b in=%0d out=%0d want g=1 in=1 out=4", grant, in_sel, out_sel); end
    wr_en = 5'b01111;
    step();
    checks++; if (grant !== 1'b1) begin errors++; $display("[TB] FAIL other_wr_ignored: got %b want 1", grant); end
    wr_en = 5'b10000;
    step();
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL xfirst_done: got %b want 0", grant); end
    clear_inputs();
  endtask

  task automatic test_loopback();
    set_data(0, hdr(2'd1, 2'd1));
    vld = 5'b00001;
    step();
    checks++; if (grant !== 1'b1 || in_sel !== 3'd0 || out_sel !== 3'd0 || err !== 1'b0) begin errors++;
      $display("[TB] FAIL loopback: got g=%b in=%0d out=%0d e=%b want g=1 in=0 out=0 e=0", grant, in_sel, out_sel, err); end
    wr_en = 5'b00001;
    step();
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL loopback_done: got %b want 0", grant); end
    clear_inputs();
  endtask

  task automatic test_uturn_abort();
    set_data(2, hdr(2'd3, 2'd0));
    vld = 5'b00100;
    step();
    checks++; if (grant !== 1'b1 || in_sel !== 3'd2 || out_sel !== 3'd2 || err !== 1'b1) begin errors++;
      $display("[TB] FAIL uturn_grant: got g=%b in=%0d out=%0d e=%b want g=1 in=2 out=2 e=1", grant, in_sel, out_sel, err); end
    wr_en = 5'b00100;
    step();
    checks++; if (grant !== 1'b0 || err !== 1'b1) begin errors++;
      $display("[TB] FAIL uturn_sticky: got g=%b e=%b want g=0 e=1", grant, err); end
    clear_inputs();
    set_data(1, hdr(2'd1, 2'd1));
    vld = 5'b00010;
    step();
    checks++; if (grant !== 1'b1 || in_sel !== 3'd1 || out_sel !== 3'd0) begin errors++;
      $display("[TB] FAIL abort_grant: got g=%b in=%0d out=%0d want g=1 in=1 out=0", grant, in_sel, out_sel); end
    vld = '0;
    step();
    checks++; if (grant !== 1'b0 || err !== 1'b1) begin errors++;
      $display("[TB] FAIL abort_idle: got g=%b e=%b want g=0 e=1", grant, err); end
    set_data(3, hdr(2'd1, 2'd1));
    vld = 5'b01110;
    step();
    checks++; if (grant !== 1'b1 || in_sel !== 3'd3) begin errors++;
      $display("[TB] FAIL abort_ptr_kept: got g=%b in=%0d want g=1 in=3", grant, in_sel); end
    wr_en = 5'b00001;
    step();
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL abort_after_done: got %b want 0", grant); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_grant();
    set_data(3, hdr(2'd1, 2'd1));
    set_data(4, hdr(2'd1, 2'd1));
    vld = 5'b01000;
    step();
    checks++; if (grant !== 1'b1 || in_sel !== 3'd3) begin errors++;
      $display("[TB] FAIL mid_pre_grant: got g=%b in=%0d want g=1 in=3", grant, in_sel); end
    #2 rst = 1'b1;
    #1;
    checks++; if (grant !== 1'b0 || in_sel !== 3'd0 || out_sel !== 3'd0 || err !== 1'b0) begin errors++;
      $display("[TB] FAIL mid_async_reset: got g=%b in=%0d out=%0d e=%b want all 0", grant, in_sel, out_sel, err); end
    step();
    rst = 1'b0;
    vld = 5'b11000;
    step();
    checks++; if (grant !== 1'b1 || in_sel !== 3'd3) begin errors++;
      $display("[TB] FAIL mid_ptr_reset: got g=%b in=%0d want g=1 in=3", grant, in_sel); end
    wr_en = 5'b00001;
    step();
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL mid_done: got %b want 0", grant); end
    wr_en = '0; vld = 5'b10000;
    step();
    checks++; if (grant !== 1'b1 || in_sel !== 3'd4 || out_sel !== 3'd0) begin errors++;
      $display("[TB] FAIL mid_port4: got g=%b in=%0d out=%0d want g=1 in=4 out=0", grant, in_sel, out_sel); end
    wr_en = 5'b00001;
    step();
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL mid_port4_done: got %b want 0", grant); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_full_skip();
    test_east_route();
    test_round_robin();
    test_x_before_y();
    test_loopback();
    test_uturn_abort();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
